// File: rtl/tm1640_pkg.sv
// Shared constants, FSM encoding and sizing helper for the TM1640 frame sequencer.
package tm1640_pkg;

  // Fixed TM1640 command bytes
  localparam logic [7:0] TM_CMD_DATA_AUTOINC = 8'h40;
  localparam logic [7:0] TM_CMD_ADDR0        = 8'hC0;
  localparam logic [3:0] TM_CMD_CTRL         = 4'b1000;

  // Positions of the fixed bytes within a frame; data bytes follow IDX_DATA0
  localparam int IDX_CMD1  = 0;
  localparam int IDX_ADDR  = 1;
  localparam int IDX_DATA0 = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } frame_state_e;

  // Bits needed to hold values 0..n-1 (at least 1)
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational hex digit to 7-segment (gfedcba, active-high) encoder.
module seg7_hex_enc (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Standard hex glyph table, lower-case b and d to keep them distinct from 8 and 0
  always_comb begin
    case (i_hex)
      4'h0:    o_seg = 7'h3F;
      4'h1:    o_seg = 7'h06;
      4'h2:    o_seg = 7'h5B;
      4'h3:    o_seg = 7'h4F;
      4'h4:    o_seg = 7'h66;
      4'h5:    o_seg = 7'h6D;
      4'h6:    o_seg = 7'h7D;
      4'h7:    o_seg = 7'h07;
      4'h8:    o_seg = 7'h7F;
      4'h9:    o_seg = 7'h6F;
      4'hA:    o_seg = 7'h77;
      4'hB:    o_seg = 7'h7C;
      4'hC:    o_seg = 7'h39;
      4'hD:    o_seg = 7'h5E;
      4'hE:    o_seg = 7'h79;
      default: o_seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/tm1640_frame_ctrl.sv
// Frame sequencer feeding the tm1640 byte driver: snapshots the display
// inputs and streams CMD1, ADDR, N segment bytes and CTRL, either on request
// or from a periodic refresh timer.
module tm1640_frame_ctrl
  import tm1640_pkg::*;
#(
  parameter int          NUM_DIGITS     = 9,
  parameter logic [23:0] REFRESH_CYCLES = 24'd12_000_000,
  parameter int          BUSY_TIMEOUT   = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [2:0]              brightness,
  input  logic                    disp_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic                    frame_busy,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic                    tm_latch,
  output logic [7:0]              tm_byte,
  output logic                    tm_end,
  input  logic                    tm_busy
);

  localparam int NUM_BYTES = NUM_DIGITS + 3;
  localparam int IDX_W     = clog2(NUM_BYTES);
  localparam int TO_W      = clog2(BUSY_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] L_IDX_CMD1  = IDX_W'(IDX_CMD1);
  localparam logic [IDX_W-1:0] L_IDX_ADDR  = IDX_W'(IDX_ADDR);
  localparam logic [IDX_W-1:0] L_IDX_DATA0 = IDX_W'(IDX_DATA0);
  localparam logic [IDX_W-1:0] L_IDX_LAST  = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] L_IDX_LASTD = IDX_W'(NUM_BYTES - 2);
  localparam logic [TO_W-1:0]  L_TIMEOUT   = TO_W'(BUSY_TIMEOUT);

  frame_state_e r_state;
  frame_state_e w_next;

  logic [IDX_W-1:0]        r_idx;
  logic [TO_W-1:0]         r_to_cnt;
  logic [23:0]             r_ref_cnt;
  logic                    r_pend;
  logic                    r_pend_req;
  logic                    r_ack;
  logic                    r_done;
  logic                    r_err;

  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [2:0]              r_bright;
  logic                    r_disp;

  logic                    w_idle;
  logic                    w_tick;
  logic                    w_start;
  logic                    w_req_start;
  logic                    w_last;
  logic                    w_byte_done;
  logic                    w_to_hit;
  logic [IDX_W-1:0]        w_didx;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic [6:0]              w_seg;
  logic [7:0]              w_byte;
  logic                    w_end;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_tick      = (REFRESH_CYCLES != 24'd0) && (r_ref_cnt == REFRESH_CYCLES - 24'd1);
  // A request, a refresh tick and a pending frame all collapse into one start
  assign w_start     = w_idle && (upd_req || w_tick || r_pend);
  assign w_req_start = w_idle && (upd_req || r_pend_req);
  assign w_last      = (r_idx == L_IDX_LAST);
  assign w_byte_done = (r_state == ST_WAIT_LO) && !tm_busy;
  assign w_to_hit    = (r_state == ST_WAIT_HI) && !tm_busy && (r_to_cnt == L_TIMEOUT);

  assign upd_ack    = r_ack;
  assign frame_done = r_done;
  assign frame_err  = r_err;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (tm_busy)       w_next = ST_WAIT_LO;
        else if (w_to_hit) w_next = ST_IDLE;
      end
      ST_WAIT_LO: if (!tm_busy) w_next = w_last ? ST_IDLE : ST_LOAD;
      default:    w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: byte and latch are presented only while handing a byte over
  always_comb begin
    tm_latch   = 1'b0;
    tm_byte    = 8'h00;
    tm_end     = 1'b0;
    frame_busy = !w_idle;
    if ((r_state == ST_LOAD) || (r_state == ST_WAIT_HI)) begin
      tm_latch = 1'b1;
      tm_byte  = w_byte;
      tm_end   = w_end;
    end
  end

  // Byte index and busy-rise timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_to_cnt <= '0;
    end else begin
      if (w_start)                 r_idx <= '0;
      else if (w_byte_done && !w_last) r_idx <= r_idx + 1'b1;

      if (r_state == ST_LOAD)      r_to_cnt <= '0;
      else if ((r_state == ST_WAIT_HI) && !tm_busy && !w_to_hit)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Refresh timer; a request-started frame restarts the period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           r_ref_cnt <= 24'd0;
    else if (w_req_start || w_tick)     r_ref_cnt <= 24'd0;
    else if (REFRESH_CYCLES != 24'd0)   r_ref_cnt <= r_ref_cnt + 24'd1;
  end

  // Pending frame flag, remembering whether any collapsed arrival was a request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_pend_req <= 1'b0;
    end else if (w_start) begin
      r_pend     <= 1'b0;
      r_pend_req <= 1'b0;
    end else if (!w_idle) begin
      if (upd_req || w_tick) r_pend     <= 1'b1;
      if (upd_req)           r_pend_req <= 1'b1;
    end
  end

  // Status pulses and the sticky timeout error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ack  <= w_req_start;
      r_done <= (w_byte_done && w_last) || w_to_hit;
      if (w_start)       r_err <= 1'b0;
      else if (w_to_hit) r_err <= 1'b1;
    end
  end

  // Input snapshot at frame start; only read while a frame is in flight
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_dig    <= digits;
      r_dp     <= dp_mask;
      r_blank  <= blank_mask;
      r_bright <= brightness;
      r_disp   <= disp_en;
    end
  end

  // Select the snapshot digit addressed by the current data byte
  always_comb begin
    w_didx  = r_idx - L_IDX_DATA0;
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_didx == IDX_W'(k)) begin
        w_nib   = r_dig[4*k +: 4];
        w_dp    = r_dp[k];
        w_blank = r_blank[k];
      end
    end
  end

  seg7_hex_enc u_seg7 (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  // Frame byte and stop-bit request for the current index
  always_comb begin
    w_byte = w_blank ? 8'h00 : {w_dp, w_seg};
    w_end  = (r_idx == L_IDX_LASTD);
    if (r_idx == L_IDX_CMD1) begin
      w_byte = TM_CMD_DATA_AUTOINC;
      w_end  = 1'b1;
    end else if (r_idx == L_IDX_ADDR) begin
      w_byte = TM_CMD_ADDR0;
      w_end  = 1'b0;
    end else if (r_idx == L_IDX_LAST) begin
      w_byte = {TM_CMD_CTRL, r_disp, r_bright};
      w_end  = 1'b1;
    end
  end

endmodule

// File: tb/tb_tm1640_frame_ctrl.sv
// Bench for tm1640_frame_ctrl: a behavioural tm1640 busy model captures every
// latched byte, and captured frames are compared to a frame-level model.
module tb_tm1640_frame_ctrl;

  localparam int ND = 9;
  localparam int NB = ND + 3;
  localparam int BT = 40;

  typedef logic [8:0] frm_t [NB];

  logic clk = 1'b0;
  logic rst;

  logic [4*ND-1:0] digits;
  logic [ND-1:0]   dp_mask, blank_mask;
  logic [2:0]      brightness;
  logic            disp_en, upd_req;
  logic            upd_ack, frame_busy, frame_done, frame_err;
  logic            tm_latch, tm_end, tm_busy;
  logic [7:0]      tm_byte;

  logic [7:0] rf_digits;
  logic [1:0] rf_dp, rf_blank;
  logic       rf_req, rf_ack, rf_fbusy, rf_fdone, rf_ferr, rf_latch, rf_end, rf_busy;
  logic [7:0] rf_byte;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tm1640_frame_ctrl #(.NUM_DIGITS(ND), .REFRESH_CYCLES(24'd0), .BUSY_TIMEOUT(BT)) u_dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .brightness(brightness), .disp_en(disp_en), .upd_req(upd_req), .upd_ack(upd_ack),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err),
    .tm_latch(tm_latch), .tm_byte(tm_byte), .tm_end(tm_end), .tm_busy(tm_busy)
  );

  tm1640_frame_ctrl #(.NUM_DIGITS(2), .REFRESH_CYCLES(24'd100), .BUSY_TIMEOUT(BT)) u_rf (
    .clk(clk), .rst(rst), .digits(rf_digits), .dp_mask(rf_dp), .blank_mask(rf_blank),
    .brightness(3'd3), .disp_en(1'b1), .upd_req(rf_req), .upd_ack(rf_ack),
    .frame_busy(rf_fbusy), .frame_done(rf_fdone), .frame_err(rf_ferr),
    .tm_latch(rf_latch), .tm_byte(rf_byte), .tm_end(rf_end), .tm_busy(rf_busy)
  );

  // tm1640 behaviour: busy rises 1 cycle after a latch and stays up 20 cycles
  int   bm_cnt;
  logic bm_prev;
  bit   stuck = 1'b0;
  assign tm_busy = !stuck && (bm_cnt != 0) && (bm_cnt <= 20);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bm_cnt  <= 0;
      bm_prev <= 1'b0;
    end else begin
      bm_prev <= tm_latch;
      if (tm_latch && !bm_prev) bm_cnt <= 21;
      else if (bm_cnt != 0)     bm_cnt <= bm_cnt - 1;
    end
  end

  // Short-busy driver for the refresh instance so its frames fit in a period
  int   rb_cnt;
  logic rb_prev;
  assign rf_busy = (rb_cnt != 0) && (rb_cnt <= 2);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_cnt  <= 0;
      rb_prev <= 1'b0;
    end else begin
      rb_prev <= rf_latch;
      if (rf_latch && !rb_prev) rb_cnt <= 3;
      else if (rb_cnt != 0)     rb_cnt <= rb_cnt - 1;
    end
  end

  // Monitors: cycle count, captured bytes, pulse counts, refresh frame starts
  logic [8:0] cap [0:1023];
  int   cap_n = 0, viol = 0, ack_n = 0, done_n = 0, cyc = 0;
  logic lat_q = 1'b0;
  int   rf_st [0:255];
  int   rf_n = 0, rf_ack_n = 0;
  logic rf_fb_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    lat_q <= tm_latch;
    if (tm_latch && !lat_q) begin
      if (cap_n < 1024) cap[cap_n] <= {tm_end, tm_byte};
      cap_n <= cap_n + 1;
      if (tm_busy) viol <= viol + 1;
    end
    if (upd_ack)    ack_n  <= ack_n + 1;
    if (frame_done) done_n <= done_n + 1;
    rf_fb_q <= rf_fbusy;
    if (rf_fbusy && !rf_fb_q) begin
      if (rf_n < 256) rf_st[rf_n] <= cyc;
      rf_n <= rf_n + 1;
    end
    if (rf_ack) rf_ack_n <= rf_ack_n + 1;
  end

  // Reference glyphs, gfedcba
  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Whole frame as {end, byte} pairs
  function automatic frm_t frame_model(input logic [4*ND-1:0] d, input logic [ND-1:0] dp,
                                       input logic [ND-1:0] bl, input logic [2:0] br,
                                       input logic en);
    frm_t f;
    f[0] = 9'h140;
    f[1] = 9'h0C0;
    for (int i = 0; i < ND; i++)
      f[2+i] = {(i == ND-1), bl[i] ? 8'h00 : {dp[i], seg_ref(d[4*i +: 4])}};
    f[NB-1] = {1'b1, 4'b1000, en, br};
    return f;
  endfunction

  task automatic pulse_req();
    @(negedge clk) upd_req = 1'b1;
    @(negedge clk) upd_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int lim, output bit ok);
    for (int i = 0; i < lim && done_n < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ok = (done_n >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_req = 1'b0; digits = '0; dp_mask = '0; blank_mask = '0;
    brightness = 3'd0; disp_en = 1'b0;
    rf_req = 1'b0; rf_digits = 8'h5A; rf_dp = 2'b10; rf_blank = 2'b00;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (tm_latch !== 1'b0)   begin n_fail++; $display("FAIL rst_latch got %b want 0", tm_latch); end
    n_chk++; if (tm_byte !== 8'h00)   begin n_fail++; $display("FAIL rst_byte got %h want 00", tm_byte); end
    n_chk++; if (tm_end !== 1'b0)     begin n_fail++; $display("FAIL rst_end got %b want 0", tm_end); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rst_fbusy got %b want 0", frame_busy); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fdone got %b want 0", frame_done); end
    n_chk++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    n_chk++; if (upd_ack !== 1'b0)    begin n_fail++; $display("FAIL rst_ack got %b want 0", upd_ack); end
    @(negedge clk) rst = 1'b1;
    repeat (60) @(negedge clk);
    n_chk++; if (cap_n !== 0) begin n_fail++; $display("FAIL powerup_noframe got %0d bytes want 0", cap_n); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL powerup_fbusy got %b want 0", frame_busy); end
  endtask

  task automatic test_basic();
    int a0, d0, c0, v0; bit ok; frm_t e;
    digits = 36'h987654321; dp_mask = '0; blank_mask = '0; brightness = 3'd7; disp_en = 1'b1;
    e = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
    a0 = ack_n; d0 = done_n; c0 = cap_n; v0 = viol;
    pulse_req();
    wait_done(d0 + 1, 2000, ok);
    repeat (5) @(negedge clk);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_done got timeout want frame_done"); end
    n_chk++; if (ack_n - a0 !== 1)  begin n_fail++; $display("FAIL basic_acks got %0d want 1", ack_n - a0); end
    n_chk++; if (done_n - d0 !== 1) begin n_fail++; $display("FAIL basic_dones got %0d want 1", done_n - d0); end
    n_chk++; if (cap_n - c0 !== NB) begin n_fail++; $display("FAIL basic_count got %0d want %0d", cap_n - c0, NB); end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (cap[c0+i] !== e[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, cap[c0+i], e[i]); end
    end
    n_chk++; if (viol !== v0) begin n_fail++; $display("FAIL basic_latch_while_busy got %0d want 0", viol - v0); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL basic_fbusy_after got %b want 0", frame_busy); end
  endtask

  task automatic test_masks();
    int c0, d0; bit ok; frm_t e;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        digits = {ND{4'hA}}; dp_mask = 9'h001; blank_mask = 9'h100;
        brightness = 3'd2; disp_en = 1'b1;
      end else begin
        digits = 36'({$urandom(), $urandom()}); dp_mask = 9'($urandom());
        blank_mask = 9'($urandom()); brightness = 3'($urandom()); disp_en = 1'($urandom());
      end
      e = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
      c0 = cap_n; d0 = done_n;
      pulse_req();
      wait_done(d0 + 1, 2000, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL masks%0d_done got timeout want frame_done", t); end
      n_chk++; if (cap_n - c0 !== NB) begin n_fail++; $display("FAIL masks%0d_count got %0d want %0d", t, cap_n - c0, NB); end
      for (int i = 0; i < NB; i++) begin
        n_chk++;
        if (cap[c0+i] !== e[i]) begin n_fail++; $display("FAIL masks%0d_byte%0d got %h want %h", t, i, cap[c0+i], e[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, c0, k; bit ok; frm_t ea, eb;
    digits = 36'({$urandom(), $urandom()}); dp_mask = 9'($urandom()); blank_mask = 9'h000;
    brightness = 3'd1; disp_en = 1'b1;
    ea = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
    a0 = ack_n; d0 = done_n; c0 = cap_n;
    pulse_req();
    k = 0;
    while (cap_n < c0 + 5 && k < 2000) begin @(negedge clk); k++; end
    digits = 36'({$urandom(), $urandom()}); dp_mask = 9'($urandom()); blank_mask = 9'($urandom());
    brightness = 3'd6; disp_en = 1'b0;
    eb = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
    upd_req = 1'b1;
    repeat (3) @(negedge clk);
    upd_req = 1'b0;
    wait_done(d0 + 2, 5000, ok);
    repeat (200) @(negedge clk);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_done got timeout want two frame_done"); end
    n_chk++; if (done_n - d0 !== 2) begin n_fail++; $display("FAIL b2b_dones got %0d want 2", done_n - d0); end
    n_chk++; if (ack_n - a0 !== 2)  begin n_fail++; $display("FAIL b2b_acks got %0d want 2", ack_n - a0); end
    n_chk++; if (cap_n - c0 !== 2*NB) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", cap_n - c0, 2*NB); end
    for (int i = 0; i < NB; i++) begin
      n_chk++;
      if (cap[c0+i] !== ea[i]) begin n_fail++; $display("FAIL b2b_f1_byte%0d got %h want %h", i, cap[c0+i], ea[i]); end
      n_chk++;
      if (cap[c0+NB+i] !== eb[i]) begin n_fail++; $display("FAIL b2b_f2_byte%0d got %h want %h", i, cap[c0+NB+i], eb[i]); end
    end
  endtask

  task automatic test_timeout();
    int d0, c0, a0, w, k; bit ok; frm_t e;
    stuck = 1'b1;
    d0 = done_n; c0 = cap_n;
    pulse_req();
    k = 0;
    while (!tm_latch && k < 20) begin @(negedge clk); k++; end
    w = 0;
    while (tm_latch && w < 1000) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    n_chk++; if (w < BT || w > BT + 2) begin n_fail++; $display("FAIL to_latch_width got %0d want %0d..%0d", w, BT, BT + 2); end
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", frame_err); end
    n_chk++; if (done_n - d0 !== 1)  begin n_fail++; $display("FAIL to_done got %0d want 1", done_n - d0); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL to_fbusy got %b want 0", frame_busy); end
    n_chk++; if (cap_n - c0 !== 1)   begin n_fail++; $display("FAIL to_bytes got %0d want 1", cap_n - c0); end
    repeat (10) @(negedge clk);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b want 1", frame_err); end
    stuck = 1'b0;
    digits = 36'({$urandom(), $urandom()}); dp_mask = '0; blank_mask = '0;
    brightness = 3'd4; disp_en = 1'b1;
    e = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
    d0 = done_n; c0 = cap_n; a0 = ack_n;
    pulse_req();
    repeat (2) @(negedge clk);
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %b want 0", frame_err); end
    wait_done(d0 + 1, 2000, ok);
    n_chk++; if (!ok || ack_n - a0 !== 1) begin n_fail++; $display("FAIL to_recover got done=%0b acks=%0d want 1/1", ok, ack_n - a0); end
    n_chk++; if (cap[c0+NB-1] !== e[NB-1]) begin n_fail++; $display("FAIL to_recover_ctrl got %h want %h", cap[c0+NB-1], e[NB-1]); end
  endtask

  task automatic test_reset_mid();
    int c0, c1, k; frm_t e;
    digits = 36'({$urandom(), $urandom()}); dp_mask = '0; blank_mask = '0;
    brightness = 3'd5; disp_en = 1'b1;
    e = frame_model(digits, dp_mask, blank_mask, brightness, disp_en);
    c0 = cap_n;
    pulse_req();
    k = 0;
    while (cap_n < c0 + 7 && k < 3000) begin @(negedge clk); k++; end
    n_chk++; if (tm_latch !== 1'b1 || {tm_end, tm_byte} !== e[6])
      begin n_fail++; $display("FAIL rmid_pre got latch=%b byte=%h want 1/%h", tm_latch, {tm_end, tm_byte}, e[6]); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (tm_latch !== 1'b0)   begin n_fail++; $display("FAIL rmid_latch got %b want 0", tm_latch); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_fbusy got %b want 0", frame_busy); end
    n_chk++; if (tm_byte !== 8'h00)   begin n_fail++; $display("FAIL rmid_byte got %h want 00", tm_byte); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c1 = cap_n;
    repeat (100) @(negedge clk);
    n_chk++; if (cap_n !== c1) begin n_fail++; $display("FAIL rmid_noframe got %0d bytes want 0", cap_n - c1); end
    n_chk++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %b want 0", frame_busy); end
  endtask

  task automatic test_refresh();
    int rel, b, a0, k, got;
    int exp_st [4];
    exp_st[0] = 100; exp_st[1] = 151; exp_st[2] = 251; exp_st[3] = 351;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    rel = cyc; b = rf_n; a0 = rf_ack_n;
    k = 0;
    while (cyc - rel < 150 && k < 400) begin @(negedge clk); k++; end
    rf_req = 1'b1;
    @(negedge clk) rf_req = 1'b0;
    k = 0;
    while (rf_n < b + 4 && k < 600) begin @(negedge clk); k++; end
    n_chk++; if (rf_n < b + 4) begin n_fail++; $display("FAIL rf_frames got %0d want 4", rf_n - b); end
    for (int i = 0; i < 4; i++) begin
      got = rf_st[b+i] - rel;
      n_chk++;
      if (rf_n < b + i + 1 || got < exp_st[i] - 2 || got > exp_st[i] + 2)
        begin n_fail++; $display("FAIL rf_start%0d got %0d want %0d", i, got, exp_st[i]); end
    end
    n_chk++; if (rf_ack_n - a0 !== 1) begin n_fail++; $display("FAIL rf_acks got %0d want 1", rf_ack_n - a0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masks();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1640_frame_ctrl.md
Name: tm1640_frame_ctrl

Overview:
- Parametrised frame sequencer for the TM1640 byte driver (tm1640 module). It generalises the fixed one-shot "123456789" instruction list.
- Takes a packed hex-digit buffer, per-digit decimal-point and blank masks, brightness and display enable.
- Encodes the digits to 7-segment and streams a complete frame (CMD1, ADDR, N data bytes, CTRL) on request or on a periodic refresh timer.
- Sits between application logic and tm1640.

Parameters:
NUM_DIGITS, 9, digits driven (1..16), written from grid address 0 upward
REFRESH_CYCLES, 24'd12_000_000, clk cycles between auto-refresh frame starts; 0 disables auto-refresh
BUSY_TIMEOUT, 1023, max cycles waiting for tm_busy to rise after latch before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
digits  in  4*NUM_DIGITS  hex value per digit, digit i at [4i+3:4i]
dp_mask  in  NUM_DIGITS  1 = light decimal point (seg bit 7) of digit i
blank_mask  in  NUM_DIGITS  1 = digit i sends 8'h00 (overrides dp)
brightness  in  3  CTRL brightness bits
disp_en  in  1  CTRL display on bit
upd_req  in  1  frame request, level-sampled each cycle
upd_ack  out  1  1-cycle pulse when a request is accepted (inputs snapshotted)
frame_busy  out  1  high from snapshot to end of CTRL byte
frame_done  out  1  1-cycle pulse after CTRL byte completes
frame_err  out  1  sticky; set on busy timeout, cleared by the next accepted frame
tm_latch  out  1  byte-valid to tm1640
tm_byte  out  8  byte to tm1640
tm_end  out  1  stop-bit request for this byte
tm_busy  in  1  tm1640 busy

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, refresh counter 0, pending flag 0, frame_err 0. Reset mid-frame aborts immediately; tm_latch drops in the same instant.
- Frame sequence, NUM_DIGITS+3 bytes, in this order:
  - CMD1 8'h40 with end=1.
  - ADDR 8'hC0 with end=0.
  - data[0..N-1]; end=1 only on the last data byte.
  - CTRL {4'b1000, disp_en, brightness} with end=1.
- Data byte i:
  - blank_mask[i] → 8'h00.
  - Otherwise {dp_mask[i], seg7(digits[i])}, where seg7 uses the standard gfedcba encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Snapshot: digits, masks, brightness and disp_en are registered at frame start. Input changes mid-frame do not affect the frame in progress.
- FSM states:
  - IDLE: if start, snapshot, pulse upd_ack (request starts only), set frame_busy, go to LOAD.
  - LOAD: drive tm_byte/tm_end for the current index, assert tm_latch, go to WAIT_HI.
  - WAIT_HI: hold tm_latch, byte and end stable until tm_busy=1, then drop tm_latch and go to WAIT_LO. If the timeout counter reaches BUSY_TIMEOUT first: drop tm_latch, set frame_err, pulse frame_done, go to IDLE.
  - WAIT_LO: wait for tm_busy=0. If the index is the last, pulse frame_done, clear frame_busy and go to IDLE; otherwise increment the index and go to LOAD.
  - The driver never sees tm_latch while tm_busy=1 from a prior byte. Minimum gap between bytes is 1 cycle.
- Start condition: upd_req=1, or the refresh tick, or the pending flag, evaluated in IDLE.
- Request and refresh handling:
  - upd_req or a refresh tick arriving while frame_busy sets pending. Multiple arrivals collapse into one pending frame.
  - The pending frame starts the cycle after returning to IDLE and acks only if it originated from upd_req.
  - upd_req and the refresh tick in the same cycle produce one frame.
- Refresh counter:
  - Free-running 0..REFRESH_CYCLES-1. It wraps to 0 and emits a tick on wrap.
  - It resets to 0 on every request-accepted frame start, so a manual update defers auto-refresh.
  - With REFRESH_CYCLES=0, no ticks are emitted.
- Power-up: the first frame starts on the first refresh tick or upd_req; no implicit frame after reset.

Decomposition:
- Package tm1640_pkg:
  - TM_CMD_DATA_AUTOINC=8'h40, TM_CMD_ADDR0=8'hC0, TM_CMD_CTRL=4'b1000.
  - Byte-index width function clog2(NUM_DIGITS+3).
  - Index constants IDX_CMD1=0, IDX_ADDR=1, IDX_DATA0=2.
- Sub-module: seg7_hex_enc, combinational 4-bit → 7-bit gfedcba encoder, instantiated once and muxed by the byte index.

Test Plan:
- Reset, then upd_req=1 with digits=36'h987654321, NUM_DIGITS=9, masks=0, brightness=7, disp_en=1, under a behavioural tm1640 busy model (busy 1 cycle after latch, 20 cycles long) → bytes 40(e1) C0(e0) 06 5B 4F 66 6D 7D 07 7F 6F(e1) 8F(e1); one upd_ack; one frame_done.
- dp_mask=9'h001, blank_mask=9'h100, digits all 4'hA → data0=F7, data1..7=77, data8=00.
- upd_req held for 3 cycles mid-frame, and brightness changed mid-frame → current frame unchanged; exactly one extra frame follows with the new CTRL.
- REFRESH_CYCLES=100, no upd_req → frames start at cycles 100, 200, …; upd_req at cycle 150 restarts the count (next auto frame ≥250).
- tm_busy stuck 0 → tm_latch drops after BUSY_TIMEOUT cycles; frame_err=1, frame_done pulse; next accepted frame clears frame_err.
- rst asserted during data byte 4 → tm_latch, frame_busy and tm_byte go 0 asynchronously; after release, no frame until a request.
